legv8_exec_core: RTL and testbench
==================================

// Module: legv8_exec_core
// PURPOSE
// - Single-cycle LEGv8-subset datapath slice: instruction decoder/controller, ALU and word data cache in one block.
// - Sits between instruction memory and the register file: takes the 32-bit instruction and both register read values.
// - Returns control signals, register fields, the sign-extended immediate, the ALU result, the zero flag and the write-back data.
// - The PC unit and register file stay outside this block.
// PARAMETERS
// - DEPTH  64  data cache words (32-bit each); byte address, word index = addr[log2(DEPTH)+1:2]
// PORTS
// - clock           in   1   single clock; all state updates on rising edge
// - reset_n         in   1   asynchronous, active-low reset
// - instruction     in   32  current instruction
// - read_data1      in   32  register value of Rn
// - read_data2      in   32  register value selected by reg2loc (Rm or Rt)
// - reg2loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write
//                   out  1   each; control signals (table below)
// - alu_control     out  4   ALU operation code
// - rn, rm, rd      out  5   each; instruction[9:5], [20:16], [4:0]
// - sign_extend     out  32  extended immediate
// - instr_id        out  4   1 ADD, 2 SUB, 3 AND, 4 ORR, 5 LDUR, 6 STUR, 7 CBZ, 8 B, 9 ADDI, 10 SUBI, 0 unknown
// - alu_result      out  32  ALU output (also the data-cache address)
// - zero            out  1   alu_result == 0
// - mem_data        out  32  cache read data; 0 when mem_read = 0
// - write_back_data out  32  mem_to_reg ? mem_data : alu_result
// BEHAVIOUR
// - Decode, ALU and cache read are combinational; only the cache array is stateful.
// - Decode by opcode priority, most significant bits first:
//   - 11-bit [31:21]: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000.
//   - 10-bit [31:22]: ADDI 1001000100, SUBI 1101000100.
//   - 8-bit [31:24]: CBZ 10110100.
//   - 6-bit [31:26]: B 000101.
// - Control signals:
//   - R-type: reg_write=1, alu_src=0, alu_control = 0010 ADD, 0110 SUB, 0000 AND, 0001 ORR.
//   - ADDI/SUBI: reg_write=1, alu_src=1, alu_control 0010/0110.
//   - LDUR: alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, alu_control 0010.
//   - STUR: reg2loc=1, alu_src=1, mem_write=1, alu_control 0010.
//   - CBZ: reg2loc=1, branch=1, alu_src=0, alu_control 0111 (pass B).
//   - B: uncondbranch=1, alu_control 0000.
//   - Unknown: all control outputs 0, alu_control 0000, instr_id 0, sign_extend 0.
// - Immediates:
//   - D-type [20:12], sign-extended.
//   - CB [23:5], sign-extended.
//   - B [25:0], sign-extended.
//   - I-type [21:10], zero-extended.
//   - R-type: 0.
// - ALU:
//   - Operand A = read_data1; operand B = alu_src ? sign_extend : read_data2.
//   - Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 pass B, 1100 NOR; any other code gives 0.
//   - Arithmetic wraps modulo 2^32; no flags besides zero.
// - Cache:
//   - Write: on rising clock edge when mem_write=1, mem[index] <= read_data2.
//   - Read: combinational from mem[index] when mem_read=1.
//   - Address bits [1:0] are ignored. Index bits above the array wrap (modulo DEPTH).
//   - Read during write in the same cycle returns the old word; the new word is visible after the edge.
//   - Reset: reset_n=0 clears every word to 0 immediately and blocks writes; reset during a write cycle discards the write.
// CONFIGURATION
// - DCACHE_PRELOAD_EN defined: reset loads mem[i] = i*4 instead of 0.
// - Undefined: reset clears to 0. Decode and ALU behaviour are identical either way.
// TESTING
// - ADD 0x8B020023, read_data1=5, read_data2=7 -> reg_write=1, rn=1, rm=2, rd=3, alu_result=12, zero=0, instr_id=1.
// - STUR 0xF8008022, read_data1=16, read_data2=0xDEAD, one clock edge -> sign_extend=8, alu_result=24, word 6 = 0xDEAD.
//   Then LDUR 0xF8408024 -> mem_data = write_back_data = 0xDEAD.
// - CBZ 0xB4000065, read_data2=0 -> branch=1, reg2loc=1, sign_extend=3, zero=1; read_data2=9 -> zero=0.
// - B 0x17FFFFFE -> uncondbranch=1, sign_extend=0xFFFFFFFE, mem_write=0, reg_write=0.
// - SUB 0xCB020023 with both operands 42 -> alu_result=0, zero=1.
//   SUBI with imm 50 on read_data1=40 -> alu_result=0xFFFFFFF6.
// - After storing 0xDEAD, pulse reset_n low mid-cycle -> LDUR of word 6 returns 0 (returns 24 with DCACHE_PRELOAD_EN).
//   Instruction 0 -> all controls 0, instr_id=0.

Source files
------------

// File: rtl/legv8_exec_core_if.sv
// legv8_exec_core_if: instruction/operand inputs and decode/ALU/cache outputs of the exec core.
// Latency: all outputs are combinational in the inputs and the current cache contents.
// Backpressure: none; no handshake, a new instruction may be presented every cycle.
//
// master: drives instruction, read_data1, read_data2; observes the results.
// slave : the exec core; consumes the inputs and drives every result signal.
interface legv8_exec_core_if;
  logic [31:0] instruction;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  logic        reg2loc;
  logic        uncondbranch;
  logic        branch;
  logic        mem_read;
  logic        mem_to_reg;
  logic        mem_write;
  logic        alu_src;
  logic        reg_write;
  logic [3:0]  alu_control;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [4:0]  rd;
  logic [31:0] sign_extend;
  logic [3:0]  instr_id;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] mem_data;
  logic [31:0] write_back_data;

  modport master (
    output instruction, read_data1, read_data2,
    input  reg2loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write,
           alu_src, reg_write, alu_control, rn, rm, rd, sign_extend, instr_id,
           alu_result, zero, mem_data, write_back_data
  );

  modport slave (
    input  instruction, read_data1, read_data2,
    output reg2loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write,
           alu_src, reg_write, alu_control, rn, rm, rd, sign_extend, instr_id,
           alu_result, zero, mem_data, write_back_data
  );
endinterface

// File: rtl/legv8_exec_core.sv
// legv8_exec_core: single-cycle LEGv8-subset decoder/controller, ALU and word data cache.
// Latency: decode, ALU and cache read are combinational; cache writes land on the rising clock edge.
// Backpressure: none; one instruction per cycle, no stall path.
//
// Ports: clock, reset_n (async active-low; clears/preloads the cache and blocks writes),
//        bus (legv8_exec_core_if.slave): instruction + register operands in, control
//        signals, register fields, immediate, ALU result, zero flag and write-back data out.
// Option: DCACHE_PRELOAD_EN defined -> reset loads word i with i*4 instead of 0.
// DEPTH must be a power of two (>= 2) so that index wrap is a plain bit-slice.
module legv8_exec_core #(
  parameter int DEPTH = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  legv8_exec_core_if.slave   bus
);

  localparam int IDXW = $clog2(DEPTH);

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  logic [31:0] ins;
  logic        reg2loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [3:0]  alu_control;
  logic [31:0] imm;
  logic [3:0]  instr_id;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic [31:0] mem_data;
  logic [IDXW-1:0] idx;
  logic [31:0] mem [DEPTH];

  assign ins = bus.instruction;

  // Decode: widest opcode field first so longer patterns win over shorter prefixes.
  always_comb begin
    reg2loc      = 1'b0;
    uncondbranch = 1'b0;
    branch       = 1'b0;
    mem_read     = 1'b0;
    mem_to_reg   = 1'b0;
    mem_write    = 1'b0;
    alu_src      = 1'b0;
    reg_write    = 1'b0;
    alu_control  = ALU_AND;
    imm          = 32'd0;
    instr_id     = 4'd0;
    if (ins[31:21] == OP_ADD) begin
      instr_id = 4'd1; reg_write = 1'b1; alu_control = ALU_ADD;
    end else if (ins[31:21] == OP_SUB) begin
      instr_id = 4'd2; reg_write = 1'b1; alu_control = ALU_SUB;
    end else if (ins[31:21] == OP_AND) begin
      instr_id = 4'd3; reg_write = 1'b1; alu_control = ALU_AND;
    end else if (ins[31:21] == OP_ORR) begin
      instr_id = 4'd4; reg_write = 1'b1; alu_control = ALU_OR;
    end else if (ins[31:21] == OP_LDUR) begin
      instr_id = 4'd5; alu_src = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1;
      reg_write = 1'b1; alu_control = ALU_ADD;
      imm = {{23{ins[20]}}, ins[20:12]};
    end else if (ins[31:21] == OP_STUR) begin
      instr_id = 4'd6; reg2loc = 1'b1; alu_src = 1'b1; mem_write = 1'b1;
      alu_control = ALU_ADD;
      imm = {{23{ins[20]}}, ins[20:12]};
    end else if (ins[31:22] == OP_ADDI) begin
      instr_id = 4'd9; reg_write = 1'b1; alu_src = 1'b1; alu_control = ALU_ADD;
      imm = {20'd0, ins[21:10]};
    end else if (ins[31:22] == OP_SUBI) begin
      instr_id = 4'd10; reg_write = 1'b1; alu_src = 1'b1; alu_control = ALU_SUB;
      imm = {20'd0, ins[21:10]};
    end else if (ins[31:24] == OP_CBZ) begin
      // CBZ tests Rt, which reg2loc routes onto read_data2; the ALU passes it through.
      instr_id = 4'd7; reg2loc = 1'b1; branch = 1'b1; alu_control = ALU_PASS;
      imm = {{13{ins[23]}}, ins[23:5]};
    end else if (ins[31:26] == OP_B) begin
      instr_id = 4'd8; uncondbranch = 1'b1; alu_control = ALU_AND;
      imm = {{6{ins[25]}}, ins[25:0]};
    end
  end

  assign op_b = alu_src ? imm : bus.read_data2;

  always_comb begin
    alu_result = 32'd0;
    case (alu_control)
      ALU_AND:  alu_result = bus.read_data1 & op_b;
      ALU_OR:   alu_result = bus.read_data1 | op_b;
      ALU_ADD:  alu_result = bus.read_data1 + op_b;
      ALU_SUB:  alu_result = bus.read_data1 - op_b;
      ALU_PASS: alu_result = op_b;
      ALU_NOR:  alu_result = ~(bus.read_data1 | op_b);
      default:  alu_result = 32'd0;
    endcase
  end

  // Byte address -> word index; upper address bits simply drop off (wrap modulo DEPTH).
  assign idx = alu_result[IDXW+1:2];

  // Reset acts on the whole array asynchronously, so a write in a reset cycle is lost.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
`ifdef DCACHE_PRELOAD_EN
        mem[i] <= 32'(i) << 2;
`else
        mem[i] <= 32'd0;
`endif
      end
    end else if (mem_write) begin
      mem[idx] <= bus.read_data2;
    end
  end

  // Read-during-write sees the pre-edge word since the array only changes on the edge.
  assign mem_data = mem_read ? mem[idx] : 32'd0;

  assign bus.reg2loc         = reg2loc;
  assign bus.uncondbranch    = uncondbranch;
  assign bus.branch          = branch;
  assign bus.mem_read        = mem_read;
  assign bus.mem_to_reg      = mem_to_reg;
  assign bus.mem_write       = mem_write;
  assign bus.alu_src         = alu_src;
  assign bus.reg_write       = reg_write;
  assign bus.alu_control     = alu_control;
  assign bus.rn              = ins[9:5];
  assign bus.rm              = ins[20:16];
  assign bus.rd              = ins[4:0];
  assign bus.sign_extend     = imm;
  assign bus.instr_id        = instr_id;
  assign bus.alu_result      = alu_result;
  assign bus.zero            = (alu_result == 32'd0);
  assign bus.mem_data        = mem_data;
  assign bus.write_back_data = mem_to_reg ? mem_data : alu_result;

endmodule

// File: tb/tb_legv8_exec_core.sv
// tb_legv8_exec_core: randomized scoreboard bench for legv8_exec_core.
// Latency: expectations are compared half a cycle after the inputs are driven.
// Backpressure: none; the driver pushes expectations, the monitor pops them at each falling edge.
module tb_legv8_exec_core;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  legv8_exec_core_if bus ();

  legv8_exec_core dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] ins;
    logic        r2l, ub, br, mr, m2r, mw, as, rw;
    logic [3:0]  aluc;
    logic [4:0]  rn, rm, rd;
    logic [31:0] imm;
    logic [3:0]  id;
    logic [31:0] res;
    logic        zero;
    logic [31:0] md;
    logic [31:0] wb;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mmem[64];
  int          checks   = 0;
  int          failures = 0;
  int          txn      = 0;
  logic        pend_wr  = 1'b0;
  int          pend_idx = 0;
  logic [31:0] pend_dat = 32'd0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s txn=%0d got=%h want=%h", name, txn, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
`ifdef DCACHE_PRELOAD_EN
      mmem[i] = 32'(i * 4);
`else
      mmem[i] = 32'd0;
`endif
    end
  endtask

  function automatic logic [31:0] sx(input int unsigned v, input int bits);
    longint r;
    r = longint'(v);
    if (((v >> (bits - 1)) & 1) != 0) r = r - (longint'(1) << bits);
    return 32'(r);
  endfunction

  // Reference behaviour built from the instruction-set rules with plain arithmetic.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b2);
    exp_t e = '{default: '0};
    int unsigned u = ins;
    logic [31:0] opb;
    e.ins = ins;
    e.rn  = 5'((u >> 5) % 32);
    e.rm  = 5'((u >> 16) % 32);
    e.rd  = 5'(u % 32);
    if      ((u >> 21) == 'h458) e.id = 1;
    else if ((u >> 21) == 'h658) e.id = 2;
    else if ((u >> 21) == 'h450) e.id = 3;
    else if ((u >> 21) == 'h550) e.id = 4;
    else if ((u >> 21) == 'h7C2) e.id = 5;
    else if ((u >> 21) == 'h7C0) e.id = 6;
    else if ((u >> 22) == 'h244) e.id = 9;
    else if ((u >> 22) == 'h344) e.id = 10;
    else if ((u >> 24) == 'hB4)  e.id = 7;
    else if ((u >> 26) == 'h05)  e.id = 8;
    else                         e.id = 0;
    case (e.id)
      1: begin e.rw = 1; e.aluc = 2; end
      2: begin e.rw = 1; e.aluc = 6; end
      3: begin e.rw = 1; e.aluc = 0; end
      4: begin e.rw = 1; e.aluc = 1; end
      5: begin e.as = 1; e.mr = 1; e.m2r = 1; e.rw = 1; e.aluc = 2; e.imm = sx((u >> 12) % 512, 9); end
      6: begin e.r2l = 1; e.as = 1; e.mw = 1; e.aluc = 2; e.imm = sx((u >> 12) % 512, 9); end
      7: begin e.r2l = 1; e.br = 1; e.aluc = 7; e.imm = sx((u >> 5) % (1 << 19), 19); end
      8: begin e.ub = 1; e.aluc = 0; e.imm = sx(u % (1 << 26), 26); end
      9: begin e.rw = 1; e.as = 1; e.aluc = 2; e.imm = (u >> 10) % 4096; end
      10: begin e.rw = 1; e.as = 1; e.aluc = 6; e.imm = (u >> 10) % 4096; end
      default: ;
    endcase
    opb = e.as ? e.imm : b2;
    case (e.id)
      1, 5, 6, 9: e.res = a + opb;
      2, 10:      e.res = a - opb;
      4:          e.res = a | opb;
      7:          e.res = opb;
      default:    e.res = a & opb;
    endcase
    e.zero = (e.res == 0);
    e.md   = e.mr ? mmem[(e.res >> 2) % 64] : 32'd0;
    e.wb   = e.m2r ? e.md : e.res;
    return e;
  endfunction

  // Called just after a rising edge: apply inputs and queue the expected response.
  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b2);
    exp_t e;
    bus.instruction = ins;
    bus.read_data1  = a;
    bus.read_data2  = b2;
    e = model(ins, a, b2);
    exp_q.push_back(e);
    pend_wr  = e.mw;
    pend_idx = int'((e.res >> 2) % 64);
    pend_dat = b2;
  endtask

  // Advance past the next rising edge; the model stores only if reset was released at that edge.
  task automatic step();
    @(posedge clock);
    if (pend_wr && reset_n) mmem[pend_idx] = pend_dat;
    pend_wr = 1'b0;
    #1;
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      txn++;
      chk("reg2loc",      32'(bus.reg2loc),      32'(e.r2l));
      chk("uncondbranch", 32'(bus.uncondbranch), 32'(e.ub));
      chk("branch",       32'(bus.branch),       32'(e.br));
      chk("mem_read",     32'(bus.mem_read),     32'(e.mr));
      chk("mem_to_reg",   32'(bus.mem_to_reg),   32'(e.m2r));
      chk("mem_write",    32'(bus.mem_write),    32'(e.mw));
      chk("alu_src",      32'(bus.alu_src),      32'(e.as));
      chk("reg_write",    32'(bus.reg_write),    32'(e.rw));
      chk("alu_control",  32'(bus.alu_control),  32'(e.aluc));
      chk("rn",           32'(bus.rn),           32'(e.rn));
      chk("rm",           32'(bus.rm),           32'(e.rm));
      chk("rd",           32'(bus.rd),           32'(e.rd));
      chk("sign_extend",  bus.sign_extend,       e.imm);
      chk("instr_id",     32'(bus.instr_id),     32'(e.id));
      chk("alu_result",   bus.alu_result,        e.res);
      chk("zero",         32'(bus.zero),         32'(e.zero));
      chk("mem_data",     bus.mem_data,          e.md);
      chk("write_back",   bus.write_back_data,   e.wb);
    end
  end

  localparam logic [31:0] WORD6_RESET =
`ifdef DCACHE_PRELOAD_EN
    32'd24;
`else
    32'd0;
`endif

  initial begin
    logic [31:0] f, a, b2, ins;
    int k;
    bus.instruction = 32'd0;
    bus.read_data1  = 32'd0;
    bus.read_data2  = 32'd0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_instr_id",  32'(bus.instr_id),  32'd0);
    chk("rst_reg_write", 32'(bus.reg_write), 32'd0);
    chk("rst_mem_data",  bus.mem_data,       32'd0);
    reset_n = 1'b1;

    // Word 6 straight after reset.
    drive(32'hF8408024, 32'd16, 32'd0); #2;
    chk("init_word6", bus.mem_data, WORD6_RESET);
    step();

    drive(32'h8B020023, 32'd5, 32'd7); #2;
    chk("add_result", bus.alu_result, 32'd12);
    chk("add_id",     32'(bus.instr_id), 32'd1);
    chk("add_rd",     32'(bus.rd), 32'd3);
    step();

    drive(32'hF8008022, 32'd16, 32'h0000DEAD); #2;
    chk("stur_imm",  bus.sign_extend, 32'd8);
    chk("stur_addr", bus.alu_result,  32'd24);
    chk("stur_old",  bus.mem_data,    32'd0);
    step();

    drive(32'hF8408024, 32'd16, 32'd0); #2;
    chk("ldur_data", bus.mem_data,        32'h0000DEAD);
    chk("ldur_wb",   bus.write_back_data, 32'h0000DEAD);
    step();

    drive(32'hB4000065, 32'd77, 32'd0); #2;
    chk("cbz_imm",  bus.sign_extend, 32'd3);
    chk("cbz_zero", 32'(bus.zero),   32'd1);
    step();
    drive(32'hB4000065, 32'd77, 32'd9); #2;
    chk("cbz_nz", 32'(bus.zero), 32'd0);
    step();

    drive(32'h17FFFFFE, 32'd1, 32'd2); #2;
    chk("b_imm", bus.sign_extend, 32'hFFFFFFFE);
    chk("b_ub",  32'(bus.uncondbranch), 32'd1);
    step();

    drive(32'hCB020023, 32'd42, 32'd42); #2;
    chk("sub_zero", 32'(bus.zero), 32'd1);
    step();

    ins = {10'b1101000100, 12'd50, 5'd1, 5'd3};
    drive(ins, 32'd40, 32'd0); #2;
    chk("subi_neg", bus.alu_result, 32'hFFFFFFF6);
    step();

    // Short reset pulse inside a cycle wipes the stored word.
    drive(32'd0, 32'd0, 32'd0);
    #1 reset_n = 1'b0;
    model_reset();
    #1 reset_n = 1'b1;
    #1;
    chk("unk_id", 32'(bus.instr_id), 32'd0);
    step();
    drive(32'hF8408024, 32'd16, 32'd0); #2;
    chk("pulse_word6", bus.mem_data, WORD6_RESET);
    step();

    // Reset held across a store edge: the store must be dropped.
    drive(32'hF8008022, 32'd16, 32'h00001234);
    #1 reset_n = 1'b0;
    model_reset();
    step();
    reset_n = 1'b1;
    drive(32'hF8408024, 32'd16, 32'd0); #2;
    chk("rstwr_word6", bus.mem_data, WORD6_RESET);
    step();

    for (int n = 0; n < 400; n++) begin
      f  = $urandom;
      a  = $urandom;
      b2 = $urandom;
      k  = $urandom_range(0, 10);
      case (k)
        1:  ins = {11'h458, f[20:0]};
        2:  ins = {11'h658, f[20:0]};
        3:  ins = {11'h450, f[20:0]};
        4:  ins = {11'h550, f[20:0]};
        5:  ins = {11'h7C2, f[20:0]};
        6:  ins = {11'h7C0, f[20:0]};
        7:  ins = {8'hB4, f[23:0]};
        8:  ins = {6'h05, f[25:0]};
        9:  ins = {10'h244, f[21:0]};
        10: ins = {10'h344, f[21:0]};
        default: ins = f;
      endcase
      if ((k == 5 || k == 6) && $urandom_range(0, 1) == 1) a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) b2 = a;
      if ($urandom_range(0, 5) == 0) b2 = 32'd0;
      drive(ins, a, b2);
      step();
    end

    bus.instruction = 32'd0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout txn=%0d", txn);
    $fatal(1, "timeout");
  end

endmodule
